alpha_trim_mean: RTL and testbench
==================================

Name: alpha_trim_mean

Overview:
- Stage directly downstream of the parallel rank sorter in the modified alpha-trimmed mean filter.
- Takes the 5x5 window pixels plus the sorter's rank-ordered index list and discards the TRIM smallest and TRIM largest pixels.
- Accumulates the remaining K = DN-2*TRIM pixels serially, then divides by K with a serial restoring divider, rounding to nearest.
- Emits one filtered pixel per window, with a one-cycle valid strobe.

Parameters:
- DN, 25, number of window pixels.
- DW, 8, pixel width.
- DW_sequence, $clog2(DN), width of one index in the sorted index list.
- TRIM, 4, pixels discarded at each end; legal range 0 <= TRIM, 2*TRIM < DN.
- K (localparam), DN-2*TRIM, number of kept pixels (17 by default).
- SUMW (localparam), DW+$clog2(K), accumulator and divider width (13 by default).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sort_finish  in  1  one-cycle pulse; sequence_sorted and data_window are valid in this cycle.
- data_window  in  DW*DN  unsorted window; pixel i is at [i*DW +: DW].
- sequence_sorted  in  DW_sequence*DN  slot r (rank r, 0 = smallest) holds the original pixel index.
- mean_out  out  DW  trimmed-mean result, held until the next result.
- mean_valid  out  1  one-cycle strobe when mean_out updates.
- busy  out  1  high whenever the FSM is not IDLE.
- start_dropped  out  1  one-cycle pulse when sort_finish arrives while not IDLE.

Behaviour:
- Reset values (asynchronous on rst high):
  - mean_out=0, mean_valid=0, busy=0, start_dropped=0.
  - FSM=IDLE; all captured data, counters, accumulator and divider registers cleared.
- FSM states: IDLE -> ACCUM -> DIVIDE -> DONE -> IDLE.
  - IDLE: on sort_finish=1, capture data_window and sequence_sorted into internal registers, set rank counter to TRIM, clear the accumulator, go to ACCUM. Let T be the edge that performs this capture.
  - ACCUM: one kept pixel per cycle.
    - acc += captured pixel at index sequence_sorted[rank].
    - An index >= DN contributes 0.
    - rank increments each cycle; after rank DN-TRIM-1 is added (K cycles), load the divider and go to DIVIDE.
  - DIVIDE: restoring division of (acc + floor(K/2)) by K, one quotient bit per cycle, SUMW cycles, MSB first, then go to DONE.
  - DONE: mean_out <= quotient saturated to 2^DW-1; mean_valid=1 for exactly this one cycle; next state IDLE.
- Latency: mean_valid is high in the cycle starting at edge T+K+SUMW+1. With default parameters this is 31 cycles after capture.
- Throughput: one window per K+SUMW+2 cycles.
- Arithmetic widths:
  - Accumulator is SUMW bits.
  - The rounded dividend (max 255*K+K/2) fits in SUMW bits with no overflow.
  - The quotient never exceeds 2^DW-1; saturation is a guard only.
- Start handling:
  - sort_finish is accepted only in IDLE.
  - If sort_finish arrives in ACCUM, DIVIDE or DONE, it is ignored, start_dropped pulses one cycle, and the in-flight computation is unaffected.
- Input stability: inputs are sampled only at the capture edge; they may change freely afterwards.
- TRIM=0 degenerates to a plain rounded mean of all DN pixels.
- Reset mid-operation: immediate return to IDLE.
  - mean_valid is never asserted for the aborted window.
  - mean_out is cleared to 0.
  - The first sort_finish after rst deasserts is accepted normally.

Test Plan:
- Flat window: all 25 pixels=100, identity index list -> mean_valid exactly 31 cycles after capture edge, mean_out=100, busy high for 31 cycles.
- Ramp: pixel i = i (0..24), identity list -> kept ranks 4..20, sum 204, (204+8)/17 -> mean_out=12.
- Outlier rejection:
  - Stimulus: pixels 0-3 = 255, pixels 4-24 = 50; list ranks 4..24 to indices 0..3 at the top and indices 4..24 below.
  - Required response: mean_out=50, all 255s excluded.
- Rounding:
  - Kept ranks hold 9 pixels of 11 and 8 pixels of 10 (sum 179), trimmed ranks hold 0 and 255 -> mean_out=11.
  - Repeat with 8x11 and 9x10 (sum 178) -> mean_out=10.
- Back-to-back:
  - Stimulus: second sort_finish 5 cycles after the first.
  - Required response: start_dropped pulses once in that cycle, only one mean_valid, value from the first window; a third sort_finish after DONE is accepted and produces its own result.
- Reset mid-ACCUM:
  - Stimulus: assert rst for 1 cycle at capture+6.
  - Required response: mean_valid never fires for that window, mean_out=0, busy=0; a new window (all 77) then yields mean_out=77 at +31 cycles.

Source files
------------

// File: rtl/alpha_trim_mean.sv
// Alpha-trimmed mean stage: drops the TRIM lowest and TRIM highest ranked pixels,
// sums the K survivors serially, then divides by K with rounding via a restoring divider.
module alpha_trim_mean #(
  parameter int DN          = 25,
  parameter int DW          = 8,
  parameter int DW_sequence = $clog2(DN),
  parameter int TRIM        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sort_finish,
  input  logic [DW*DN-1:0]          data_window,
  input  logic [DW_sequence*DN-1:0] sequence_sorted,
  output logic [DW-1:0]             mean_out,
  output logic                      mean_valid,
  output logic                      busy,
  output logic                      start_dropped
);

  localparam int K    = DN - 2*TRIM;
  localparam int SUMW = DW + $clog2(K);
  localparam int RW   = $clog2(DN + 1);
  localparam int CW   = $clog2(SUMW + 1);
  localparam logic [SUMW:0]   K_EXT  = (SUMW+1)'(K);
  localparam logic [SUMW-1:0] K_S    = SUMW'(K);
  localparam logic [SUMW-1:0] K_HALF = SUMW'(K / 2);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t                    state_q, state_d;
  logic [DW*DN-1:0]          win_q, win_d;
  logic [DW_sequence*DN-1:0] seq_q, seq_d;
  logic [RW-1:0]             rank_q, rank_d;
  logic [SUMW-1:0]           acc_q, acc_d;
  logic [SUMW-1:0]           div_q, div_d;
  logic [SUMW-1:0]           quo_q, quo_d;
  logic [SUMW-1:0]           rem_q, rem_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DW-1:0]             mean_q, mean_d;
  logic                      mean_valid_q, mean_valid_d;
  logic                      dropped_q, dropped_d;

  logic [DW_sequence-1:0]    idx;
  logic [DW-1:0]             pix;
  logic [SUMW-1:0]           acc_sum;
  logic [SUMW:0]             rem_shift;
  logic                      rem_ge;

  function automatic logic [DW-1:0] sat_pixel(input logic [SUMW-1:0] q);
    if (q > SUMW'({DW{1'b1}})) return {DW{1'b1}};
    return q[DW-1:0];
  endfunction

  // Rank -> original index -> pixel; out-of-range indices select nothing and read as 0
  always_comb begin
    idx = '0;
    pix = '0;
    for (int r = 0; r < DN; r++)
      if (rank_q == RW'(r)) idx = seq_q[r*DW_sequence +: DW_sequence];
    for (int i = 0; i < DN; i++)
      if (idx == DW_sequence'(i)) pix = win_q[i*DW +: DW];
  end

  assign acc_sum   = acc_q + SUMW'(pix);
  assign rem_shift = {rem_q, div_q[SUMW-1]};
  assign rem_ge    = rem_shift >= K_EXT;

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    seq_d        = seq_q;
    rank_d       = rank_q;
    acc_d        = acc_q;
    div_d        = div_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    mean_d       = mean_q;
    mean_valid_d = 1'b0;
    dropped_d    = sort_finish && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (sort_finish) begin
          win_d   = data_window;
          seq_d   = sequence_sorted;
          rank_d  = RW'(TRIM);
          acc_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        if (rank_q == RW'(DN - TRIM - 1)) begin
          // Rounding bias folded into the dividend as it is loaded
          div_d   = acc_sum + K_HALF;
          quo_d   = '0;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIVIDE;
        end else begin
          rank_d = rank_q + RW'(1);
        end
      end
      DIVIDE: begin
        div_d = div_q << 1;
        quo_d = {quo_q[SUMW-2:0], rem_ge};
        rem_d = rem_ge ? (rem_shift[SUMW-1:0] - K_S) : rem_shift[SUMW-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SUMW - 1)) state_d = DONE;
      end
      DONE: begin
        mean_d       = sat_pixel(quo_q);
        mean_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      win_q        <= '0;
      seq_q        <= '0;
      rank_q       <= '0;
      acc_q        <= '0;
      div_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      mean_q       <= '0;
      mean_valid_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      seq_q        <= seq_d;
      rank_q       <= rank_d;
      acc_q        <= acc_d;
      div_q        <= div_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      mean_q       <= mean_d;
      mean_valid_q <= mean_valid_d;
      dropped_q    <= dropped_d;
    end
  end

  assign mean_out      = mean_q;
  assign mean_valid    = mean_valid_q;
  assign busy          = (state_q != IDLE);
  assign start_dropped = dropped_q;

endmodule

// File: tb/tb_alpha_trim_mean.sv
// Scoreboard bench for alpha_trim_mean: directed windows push expected means and
// capture times; a negedge monitor checks value and latency of every mean_valid.
module tb_alpha_trim_mean;
  localparam int DN = 25;
  localparam int DW = 8;
  localparam int SW = 5;
  localparam int LAT = 31;

  typedef struct {
    int val;
    int tcap;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                sort_finish;
  logic [DW*DN-1:0]    data_window;
  logic [SW*DN-1:0]    sequence_sorted;
  logic [DW-1:0]       mean_out;
  logic                mean_valid;
  logic                busy;
  logic                start_dropped;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_drops = 0;

  alpha_trim_mean dut (
    .clk             (clk),
    .rst             (rst),
    .sort_finish     (sort_finish),
    .data_window     (data_window),
    .sequence_sorted (sequence_sorted),
    .mean_out        (mean_out),
    .mean_valid      (mean_valid),
    .busy            (busy),
    .start_dropped   (start_dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every mean_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && start_dropped) n_drops++;
    if (!rst && mean_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", int'(mean_out), -1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mean_value", int'(mean_out), e.val);
        chk("mean_latency", cyc - e.tcap, LAT);
      end
    end
  end

  function automatic logic [DW*DN-1:0] flat(input int v);
    logic [DW*DN-1:0] w;
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = DW'(v);
    return w;
  endfunction

  function automatic logic [SW*DN-1:0] ident();
    logic [SW*DN-1:0] s;
    for (int r = 0; r < DN; r++) s[r*SW +: SW] = SW'(r);
    return s;
  endfunction

  // Drives one sort_finish pulse; returns just after the capture edge
  task automatic send(input logic [DW*DN-1:0] w, input logic [SW*DN-1:0] s,
                      input int exp, input bit push);
    @(posedge clk);
    #1;
    data_window     = w;
    sequence_sorted = s;
    sort_finish     = 1'b1;
    @(posedge clk);
    #1;
    sort_finish     = 1'b0;
    data_window     = '1;
    sequence_sorted = '1;
    if (push) q.push_back('{exp, cyc});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    logic [DW*DN-1:0] w;
    logic [SW*DN-1:0] s;
    int bcnt;

    rst = 1'b1;
    sort_finish = 1'b0;
    data_window = '0;
    sequence_sorted = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_mean_out", int'(mean_out), 0);
    chk("reset_mean_valid", int'(mean_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_start_dropped", int'(start_dropped), 0);

    // Flat window, busy duration
    send(flat(100), ident(), 100, 1'b1);
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      else break;
    end
    chk("busy_cycles", bcnt, 31);

    // Ramp
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = DW'(i);
    send(w, ident(), 12, 1'b1);
    wait_idle();

    // Outliers at the top ranks
    w = flat(50);
    for (int i = 0; i < 4; i++) w[i*DW +: DW] = 8'd255;
    for (int r = 0; r < DN; r++) s[r*SW +: SW] = (r < 21) ? SW'(r + 4) : SW'(r - 21);
    send(w, s, 50, 1'b1);
    wait_idle();

    // Rounding up: 9x11 + 8x10 = 179
    w = '0;
    for (int i = 4; i <= 12; i++) w[i*DW +: DW] = 8'd11;
    for (int i = 13; i <= 20; i++) w[i*DW +: DW] = 8'd10;
    for (int i = 21; i < DN; i++) w[i*DW +: DW] = 8'd255;
    send(w, ident(), 11, 1'b1);
    wait_idle();

    // Rounding down: 8x11 + 9x10 = 178
    for (int i = 4; i <= 11; i++) w[i*DW +: DW] = 8'd11;
    for (int i = 12; i <= 20; i++) w[i*DW +: DW] = 8'd10;
    send(w, ident(), 10, 1'b1);
    wait_idle();

    // Out-of-range index at a kept rank contributes 0: 16x17 = 272 -> 16
    s = ident();
    s[10*SW +: SW] = 5'd31;
    send(flat(17), s, 16, 1'b1);
    wait_idle();

    // Back-to-back: second start dropped, third accepted
    send(flat(60), ident(), 60, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    data_window = flat(200);
    sequence_sorted = ident();
    sort_finish = 1'b1;
    @(posedge clk);
    #1 sort_finish = 1'b0;
    @(negedge clk);
    chk("start_dropped_pulse", int'(start_dropped), 1);
    chk("busy_while_dropped", int'(busy), 1);
    wait_idle();
    send(flat(33), ident(), 33, 1'b1);
    wait_idle();

    // Reset during ACCUM
    send(flat(90), ident(), 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_mean_out", int'(mean_out), 0);
    chk("abort_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_valid_pending", q.size(), 0);
    send(flat(77), ident(), 77, 1'b1);
    wait_idle();

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    chk("start_dropped_total", n_drops, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
